// File: rtl/counter_arbiter.sv
// Round-robin arbiter that time-shares one enable/reset counter between NREQ
// requesters, running each granted job for exactly len counted cycles.
module counter_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]   grant,
  output logic              done,
  output logic              abort,
  output logic [CW-1:0]     result,
  output logic              cnt_reset,
  output logic              cnt_enable,
  input  logic [CW-1:0]     cnt_value
);

  localparam int          PW = $clog2(NREQ);
  localparam int unsigned NR = NREQ;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   last, last_n;
  logic [CW-1:0]   len_q, len_n;
  logic [NREQ-1:0] grant_n;
  logic            abort_n;
  logic [CW-1:0]   result_n;
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand;

  // Search upward from last+1 with wrap; the previous winner is considered last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NR; i++) begin
      cand = PW'((32'(last) + i) % NR);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // While a job is active, last holds the owner index.
  always_comb begin
    state_n    = state;
    last_n     = last;
    len_n      = len_q;
    grant_n    = grant;
    abort_n    = abort;
    result_n   = result;
    cnt_reset  = 1'b0;
    cnt_enable = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        abort_n = 1'b0;
        if (win_found) begin
          grant_n = NREQ'(1) << win_idx;
          last_n  = win_idx;
          len_n   = len[win_idx*CW +: CW];
          state_n = CLEAR;
        end
      end
      CLEAR: begin
        cnt_reset = 1'b1;
        state_n   = RUN;
      end
      RUN: begin
        cnt_enable = (cnt_value != len_q) && req[last];
        if (cnt_value == len_q) begin
          abort_n  = 1'b0;
          result_n = cnt_value;
          state_n  = DONE;
        end else if (!req[last]) begin
          abort_n  = 1'b1;
          result_n = cnt_value;
          state_n  = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        grant_n = '0;
        abort_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      last   <= PW'(NREQ - 1);
      len_q  <= '0;
      grant  <= '0;
      abort  <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_n;
      last   <= last_n;
      len_q  <= len_n;
      grant  <= grant_n;
      abort  <= abort_n;
      result <= result_n;
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter; includes a behavioural model of the
// shared enable/reset counter that the arbiter drives.
module tb_counter_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      req;
  logic [15:0]     len;
  logic [3:0]      grant;
  logic            done;
  logic            abort;
  logic [3:0]      result;
  logic            cnt_reset;
  logic            cnt_enable;
  logic [3:0]      cnt_value = 4'hA;

  int errors = 0;
  int checks = 0;

  counter_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .len        (len),
    .grant      (grant),
    .done       (done),
    .abort      (abort),
    .result     (result),
    .cnt_reset  (cnt_reset),
    .cnt_enable (cnt_enable),
    .cnt_value  (cnt_value)
  );

  always #5 clk = ~clk;

  // Shared counter: synchronous reset, not tied to the arbiter's reset.
  always @(posedge clk) begin
    if (cnt_reset) cnt_value <= 4'd0;
    else if (cnt_enable) cnt_value <= cnt_value + 4'd1;
  end

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b0000;
    len   = 16'h0000;
    @(posedge clk);
    #1;
    checks++;
    if ({grant, done, abort, result, cnt_reset, cnt_enable} !== 12'b0) begin
      errors++;
      $display("FAIL reset: got grant=%b done=%b abort=%b result=%0d crst=%b en=%b want all 0",
               grant, done, abort, result, cnt_reset, cnt_enable);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [6:0] obs, exp;
    @(negedge clk);
    len[3:0] = 4'd5;
    req      = 4'b0001;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      #1;
      obs = {grant, cnt_reset, cnt_enable, done};
      exp = {((k <= 8) ? 4'b0001 : 4'b0000), (k == 1), (k >= 2 && k <= 6), (k == 8)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL single c%0d: got {grant,crst,en,done}=%b want %b", k, obs, exp);
      end
      if (k == 8) begin
        checks++;
        if (result !== 4'd5 || abort !== 1'b0) begin
          errors++;
          $display("FAIL single_result: got result=%0d abort=%b want 5 0", result, abort);
        end
        req = 4'b0000;
      end
    end
  endtask

  task automatic test_round_robin();
    logic [6:0] obs, exp;
    logic [3:0] eg;
    int j, p;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    len   = {4{4'd2}};
    req   = 4'b1111;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      #1;
      j  = (k - 1) / 6;
      p  = (k - 1) % 6;
      eg = (p == 5) ? 4'b0000 : (4'b0001 << (j % 4));
      obs = {grant, cnt_reset, cnt_enable, done};
      exp = {eg, (p == 0), (p == 1 || p == 2), (p == 4)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rr c%0d: got {grant,crst,en,done}=%b want %b", k, obs, exp);
      end
      if (p == 4) begin
        checks++;
        if (result !== 4'd2 || abort !== 1'b0) begin
          errors++;
          $display("FAIL rr_result job%0d: got result=%0d abort=%b want 2 0", j, result, abort);
        end
        if (k == 29) req = 4'b0000;
      end
    end
  endtask

  task automatic test_zero_len();
    logic [6:0] obs, exp;
    @(negedge clk);
    len = 16'h0000;
    req = 4'b0100;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #1;
      obs = {grant, cnt_reset, cnt_enable, done};
      exp = {((k <= 3) ? 4'b0100 : 4'b0000), (k == 1), 1'b0, (k == 3)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL zero c%0d: got {grant,crst,en,done}=%b want %b", k, obs, exp);
      end
      if (k == 3) begin
        checks++;
        if (result !== 4'd0 || abort !== 1'b0) begin
          errors++;
          $display("FAIL zero_result: got result=%0d abort=%b want 0 0", result, abort);
        end
        req = 4'b0000;
      end
    end
  endtask

  task automatic test_abort();
    logic [6:0] obs, exp;
    @(negedge clk);
    len[7:4] = 4'd10;
    req      = 4'b0010;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 5) req = 4'b0000;
      #1;
      obs = {grant, cnt_reset, cnt_enable, done};
      exp = {((k <= 6) ? 4'b0010 : 4'b0000), (k == 1), (k >= 2 && k <= 4), (k == 6)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort c%0d: got {grant,crst,en,done}=%b want %b", k, obs, exp);
      end
      if (k == 5) begin
        checks++;
        if (cnt_value !== 4'd3) begin
          errors++;
          $display("FAIL abort_cnt: got cnt_value=%0d want 3", cnt_value);
        end
      end
      if (k == 6) begin
        checks++;
        if (result !== 4'd3 || abort !== 1'b1) begin
          errors++;
          $display("FAIL abort_result: got result=%0d abort=%b want 3 1", result, abort);
        end
      end
      if (k == 7) begin
        checks++;
        if (abort !== 1'b0) begin
          errors++;
          $display("FAIL abort_clear: got abort=%b want 0", abort);
        end
      end
    end
  endtask

  task automatic test_drop_at_finish();
    logic [6:0] obs, exp;
    @(negedge clk);
    len[15:12] = 4'd4;
    req        = 4'b1000;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 6) req = 4'b0000;
      #1;
      obs = {grant, cnt_reset, cnt_enable, done};
      exp = {((k <= 7) ? 4'b1000 : 4'b0000), (k == 1), (k >= 2 && k <= 5), (k == 7)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL drop c%0d: got {grant,crst,en,done}=%b want %b", k, obs, exp);
      end
      if (k == 7) begin
        checks++;
        if (result !== 4'd4 || abort !== 1'b0) begin
          errors++;
          $display("FAIL drop_result: got result=%0d abort=%b want 4 0", result, abort);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [6:0] obs, exp;
    @(negedge clk);
    len[3:0]   = 4'd9;
    len[15:12] = 4'd1;
    req        = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) begin
        reset = 1'b1;
        req   = 4'b1000;
      end
      #1;
      if (k < 4) begin
        checks++;
        if (grant !== 4'b0001) begin
          errors++;
          $display("FAIL midrst_grant c%0d: got %b want 0001", k, grant);
        end
      end else begin
        checks++;
        if ({grant, done, abort, result, cnt_reset, cnt_enable} !== 12'b0) begin
          errors++;
          $display("FAIL midrst_async: got grant=%b done=%b abort=%b result=%0d crst=%b en=%b want all 0",
                   grant, done, abort, result, cnt_reset, cnt_enable);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (cnt_value !== 4'd2 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_hold: got cnt_value=%0d grant=%b want 2 0000", cnt_value, grant);
    end
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      #1;
      obs = {grant, cnt_reset, cnt_enable, done};
      exp = {((k <= 4) ? 4'b1000 : 4'b0000), (k == 1), (k == 2), (k == 4)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL midrst_rerun c%0d: got {grant,crst,en,done}=%b want %b", k, obs, exp);
      end
      if (k == 2) begin
        checks++;
        if (cnt_value !== 4'd0) begin
          errors++;
          $display("FAIL midrst_recleared: got cnt_value=%0d want 0", cnt_value);
        end
      end
      if (k == 4) begin
        checks++;
        if (result !== 4'd1 || abort !== 1'b0) begin
          errors++;
          $display("FAIL midrst_result: got result=%0d abort=%b want 1 0", result, abort);
        end
        req = 4'b0000;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_abort();
    test_drop_at_finish();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
